// File: rtl/fetch_seq.sv
// Instruction-fetch sequencer: owns the PC, fetches over a req/gnt/rvalid
// memory protocol and hands each instruction to the datapath with valid/ack.
module fetch_seq #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ack,
  input  logic        SaltoCond,
  input  logic        oZero,
  input  logic [31:0] extSigno,
  input  logic        Saltoincond,
  input  logic [27:0] jmp_target,
  input  logic        halt,
  output logic        halted,
  output logic        fetch_err,
  output logic [31:0] retired
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_REQ    = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_ISSUE  = 3'd3;
  localparam logic [2:0] S_HALTED = 3'd4;

  // The timer starts at 0 in the first WAIT cycle, so this is the last cycle allowed.
  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

  logic [2:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic [31:0] retired_q, retired_d;
  logic [15:0] timer_q, timer_d;
  logic        err_q, err_d;
  logic [31:0] pc_plus1;
  logic [31:0] next_pc;

  always_comb begin
    pc_plus1 = pc_q + 32'd1;
    if (Saltoincond) begin
      next_pc = {pc_plus1[31:28], jmp_target};
    end else if (SaltoCond && oZero) begin
      next_pc = pc_plus1 + extSigno;
    end else begin
      next_pc = pc_plus1;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    retired_d  = retired_q;
    timer_d    = timer_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_REQ;
      end
      S_REQ: begin
        if (imem_gnt) begin
          if (imem_rvalid) begin
            instr_d    = imem_rdata;
            instr_pc_d = pc_q;
            state_d    = S_ISSUE;
          end else begin
            timer_d = 16'd0;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          instr_d    = imem_rdata;
          instr_pc_d = pc_q;
          state_d    = S_ISSUE;
        end else if (timer_q == TIMER_LAST) begin
          err_d   = 1'b1;
          state_d = S_HALTED;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      S_ISSUE: begin
        if (instr_ack) begin
          pc_d = next_pc;
          if (retired_q != 32'hFFFF_FFFF) retired_d = retired_q + 32'd1;
          if (halt) begin
            state_d = S_HALTED;
          end else if (run) begin
            state_d = S_REQ;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_HALTED: begin
        state_d = S_HALTED;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= 32'd0;
      instr_pc_q <= 32'd0;
      retired_q  <= 32'd0;
      timer_q    <= 16'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      retired_q  <= retired_d;
      timer_q    <= timer_d;
      err_q      <= err_d;
    end
  end

  // Status outputs decode straight from the state register so reset clears them at once.
  assign imem_req    = (state_q == S_REQ);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == S_ISSUE);
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign halted      = (state_q == S_HALTED);
  assign fetch_err   = err_q;
  assign retired     = retired_q;

endmodule
